// File: rtl/hazard_stall_unit.sv
`timescale 1ns/1ps
// hazard_stall_unit: stall, bubble and flush controls for load-use, HI/LO busy and taken-branch hazards.
// Optional build macro HAZARD_STALL_CNT_EN adds a saturating 16-bit stall cycle counter on stall_cycles.
module hazard_stall_unit #(
  parameter int MULDIV_LATENCY = 32,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_muldiv,
  input  logic        id_uses_hilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dest,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        muldiv_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, hilo_haz, stall, issue;

  assign muldiv_busy = (state_q == BUSY);

  // A taken branch makes the ID instruction wrong-path, so it neither stalls nor issues.
  always_comb begin
    load_use = ex_mem_read && (ex_dest != 5'd0) &&
               ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    hilo_haz = muldiv_busy && (id_muldiv || id_uses_hilo);
    stall    = (load_use || hilo_haz) && !ex_branch_taken;
    issue    = id_muldiv && !stall && !ex_branch_taken;
  end

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall || ex_branch_taken;
  assign ifid_flush  = ex_branch_taken;

  // While BUSY any new mult/div is held by hilo_haz, so issue only matters in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          cnt_d   = CNT_W'(MULDIV_LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
`timescale 1ns/1ps
// tb_hazard_stall_unit: directed and randomized checks of hazard_stall_unit against a cycle-stamp reference model.
module tb_hazard_stall_unit;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_dest;
  logic        id_uses_rt, id_muldiv, id_uses_hilo, ex_mem_read, ex_branch_taken;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  // Model: HI/LO is busy while the edge count is below the stamp recorded at issue.
  int cyc = 0;
  int ready_cyc = 0;
  int stall_total = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_LATENCY(LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv(id_muldiv), .id_uses_hilo(id_uses_hilo), .ex_mem_read(ex_mem_read),
    .ex_dest(ex_dest), .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  function automatic logic m_busy();
    return rst_n && (cyc < ready_cyc);
  endfunction

  function automatic logic m_stall();
    logic lu;
    logic hz;
    lu = ex_mem_read && (ex_dest != 5'd0) &&
         ((ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt)));
    hz = m_busy() && (id_muldiv || id_uses_hilo);
    return (lu || hz) && !ex_branch_taken;
  endfunction

  // Expected {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}.
  function automatic logic [4:0] exp_ctrl();
    logic s;
    s = m_stall();
    return {!s, !s, s || ex_branch_taken, ex_branch_taken, m_busy()};
  endfunction

  function automatic logic [15:0] exp_sc();
`ifdef HAZARD_STALL_CNT_EN
    return 16'(stall_total);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0;
    id_uses_rt = 1'b0; id_muldiv = 1'b0; id_uses_hilo = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    ready_cyc = 0;
    stall_total = 0;
  endtask

  // Advance one clock: model updates from the inputs held across the rising edge.
  task automatic tick();
    logic s;
    s = m_stall();
    @(posedge clk);
    if (rst_n) begin
      if (id_muldiv && !s && !ex_branch_taken) ready_cyc = cyc + 1 + LAT;
      if (s && stall_total < 65535) stall_total++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    assert_reset();
    #1;
    n_cmp++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy} !== 5'b11000) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b",
               {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}, 5'b11000);
    end
    n_cmp++;
    if (stall_cycles !== 16'h0000) begin
      n_err++;
      $display("[TB] FAIL reset_stall_cycles: got %h expected 0000", stall_cycles);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    logic [4:0] pat [6];
    logic [4:0] exp;
    // {ex_mem_read, dest==rs hit, dest is r0, uses_rt, rt hit}
    pat = '{5'b11000, 5'b11100, 5'b10011, 5'b10001, 5'b00010, 5'b10000};
    for (int i = 0; i < 6; i++) begin
      set_idle();
      ex_mem_read = pat[i][4];
      ex_dest     = pat[i][2] ? 5'd0 : (pat[i][1] ? 5'd7 : 5'd5);
      id_rs       = pat[i][3] ? ex_dest : 5'd9;
      id_uses_rt  = pat[i][1];
      id_rt       = pat[i][0] ? ex_dest : 5'd11;
      #1;
      exp = exp_ctrl();
      n_cmp++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy} !== exp) begin
        n_err++;
        $display("[TB] FAIL load_use[%0d]: got %b expected %b", i,
                 {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}, exp);
      end
      tick();
      // The load moves to MEM; a bubble sits in EX so the consumer proceeds.
      ex_mem_read = 1'b0;
      #1;
      n_cmp++;
      if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL load_use_release[%0d]: got pc_write=%b idex_bubble=%b expected 1 0",
                 i, pc_write, idex_bubble);
      end
      tick();
    end
    n_cmp++;
    if (stall_cycles !== exp_sc()) begin
      n_err++;
      $display("[TB] FAIL load_use_stall_cycles: got %0d expected %0d", stall_cycles, exp_sc());
    end
  endtask

  task automatic test_hilo();
    int stalls;
    int sc_before;
    logic [4:0] exp;
    set_idle();
    id_muldiv = 1'b1;
    #1;
    n_cmp++;
    if (muldiv_busy !== 1'b0 || pc_write !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL hilo_issue: got busy=%b pc_write=%b expected 0 1", muldiv_busy, pc_write);
    end
    tick();
    sc_before = stall_cycles;
    id_muldiv = 1'b0;
    id_uses_hilo = 1'b1;
    stalls = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      #1;
      exp = exp_ctrl();
      n_cmp++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy} !== exp) begin
        n_err++;
        $display("[TB] FAIL hilo_cycle[%0d]: got %b expected %b", i,
                 {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}, exp);
      end
      if (pc_write !== 1'b0) break;
      stalls++;
      tick();
    end
    n_cmp++;
    if (stalls !== LAT) begin
      n_err++;
      $display("[TB] FAIL hilo_stall_len: got %0d expected %0d", stalls, LAT);
    end
    n_cmp++;
`ifdef HAZARD_STALL_CNT_EN
    if (int'(stall_cycles) - sc_before !== LAT) begin
      n_err++;
      $display("[TB] FAIL hilo_stall_cycles_delta: got %0d expected %0d",
               int'(stall_cycles) - sc_before, LAT);
    end
`else
    if (stall_cycles !== 16'h0000) begin
      n_err++;
      $display("[TB] FAIL hilo_stall_cycles: got %0d expected 0 (sc_before %0d)", stall_cycles, sc_before);
    end
`endif
    tick();
  endtask

  task automatic test_flush();
    set_idle();
    ex_mem_read = 1'b1; ex_dest = 5'd5; id_rs = 5'd5;
    ex_branch_taken = 1'b1; id_muldiv = 1'b1;
    #1;
    n_cmp++;
    if ({pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy} !== 5'b11110) begin
      n_err++;
      $display("[TB] FAIL flush_priority: got %b expected %b",
               {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}, 5'b11110);
    end
    tick();
    set_idle();
    #1;
    n_cmp++;
    if (muldiv_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL flush_no_issue: got busy=%b expected 0", muldiv_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    set_idle();
    id_muldiv = 1'b1;
    tick();
    id_muldiv = 1'b0;
    for (int i = 0; i < LAT - 20; i++) tick();
    #1;
    n_cmp++;
    if (muldiv_busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mid_busy_pre: got busy=%b expected 1", muldiv_busy);
    end
    #1;
    assert_reset();
    #1;
    n_cmp++;
    if (muldiv_busy !== 1'b0 || stall_cycles !== 16'h0000) begin
      n_err++;
      $display("[TB] FAIL mid_busy_async: got busy=%b stall_cycles=%0d expected 0 0",
               muldiv_busy, stall_cycles);
    end
    tick();
    rst_n = 1'b1;
    id_uses_hilo = 1'b1;
    #1;
    n_cmp++;
    if (pc_write !== 1'b1 || muldiv_busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL mid_busy_after: got pc_write=%b busy=%b expected 1 0", pc_write, muldiv_busy);
    end
    tick();
  endtask

  task automatic test_random();
    logic [4:0] exp;
    for (int i = 0; i < 600; i++) begin
      id_rs           = 5'($urandom_range(0, 5));
      id_rt           = 5'($urandom_range(0, 5));
      ex_dest         = 5'($urandom_range(0, 5));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      id_muldiv       = ($urandom_range(0, 5) == 0);
      id_uses_hilo    = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) assert_reset();
      else rst_n = 1'b1;
      #1;
      exp = exp_ctrl();
      n_cmp++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy} !== exp) begin
        n_err++;
        $display("[TB] FAIL random_ctrl[%0d]: got %b expected %b", i,
                 {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}, exp);
      end
      n_cmp++;
      if (stall_cycles !== exp_sc()) begin
        n_err++;
        $display("[TB] FAIL random_stall_cycles[%0d]: got %0d expected %0d", i, stall_cycles, exp_sc());
      end
      tick();
    end
    rst_n = 1'b1;
    set_idle();
    tick();
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_saturation();
    set_idle();
    ex_mem_read = 1'b1; ex_dest = 5'd3; id_rs = 5'd3;
    for (int i = 0; i < 65600; i++) tick();
    #1;
    n_cmp++;
    if (stall_cycles !== 16'hFFFF || exp_sc() !== 16'hFFFF) begin
      n_err++;
      $display("[TB] FAIL saturation: got %h expected ffff (model %h)", stall_cycles, exp_sc());
    end
    set_idle();
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_hilo();
    test_flush();
    test_reset_mid_busy();
    test_random();
`ifdef HAZARD_STALL_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
